// File: rtl/apb_fifo_pkg.sv
// Shared constants and types for the APB-to-fifo bridge and its level counter.
// Register offsets are byte addresses; only bits [3:2] of paddr select a register.
package apb_fifo_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_THRESH = 4'hC;

    localparam int STS_EMPTY     = 0;
    localparam int STS_FULL      = 1;
    localparam int STS_OVF       = 2;
    localparam int STS_UDF       = 3;
    localparam int STS_LEVEL_LSB = 8;
    localparam int STS_LEVEL_W   = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // A counter that holds 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_level_cnt.sv
// Shadow fill-level counter for a fifo: counts pushes up and pops down, range 0..DEPTH.
// Saturates at both ends so a stray strobe can never wrap the level.
module fifo_level_cnt
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [LVL_W-1:0] level_o
);

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    always_comb begin
        level_d = level_q;
        if (inc_i && !dec_i && (level_q != LVL_W'(DEPTH))) begin
            level_d = level_q + 1'b1;
        end else if (dec_i && !inc_i && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/apb_fifo_bridge.sv
// APB3 slave giving register-mapped push/pop access to a fifo, with sticky error flags.
// Define APB_FIFO_IRQ_EN to add the THRESH register at 0xC and the registered irq output.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no read outstanding; every access completes in its first cycle
//  RD_WAIT | fifo popped last cycle; return fifo_dout and complete
module apb_fifo_bridge
    import apb_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int PDATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [PDATA_W-1:0] pwdata,
    output logic [PDATA_W-1:0] prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               fifo_wr_en,
    output logic [WIDTH-1:0]   fifo_din,
    output logic               fifo_rd_en,
    input  logic [WIDTH-1:0]   fifo_dout,
    input  logic               fifo_full,
    input  logic               fifo_empty
`ifdef APB_FIFO_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int LVL_W = level_width(DEPTH);

    state_e             state_q, state_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               ovf_set, ovf_clr;
    logic               udf_set, udf_clr;
    logic [LVL_W-1:0]   level;
    logic               access;
    logic [3:0]         reg_off;
    logic [PDATA_W-1:0] status_word;
    logic               unused_bits;

`ifdef APB_FIFO_IRQ_EN
    logic [7:0] thresh_q, thresh_d;
    logic       irq_q;
`endif

    // Reset masks the bus so nothing in flight can strobe the fifo.
    assign access  = psel & penable & ~rst;
    assign reg_off = {paddr[3:2], 2'b00};
    assign fifo_din = pwdata[WIDTH-1:0];
    assign unused_bits = ^{paddr, pwdata};

    always_comb begin
        status_word = '0;
        status_word[STS_EMPTY] = fifo_empty;
        status_word[STS_FULL]  = fifo_full;
        status_word[STS_OVF]   = ovf_q;
        status_word[STS_UDF]   = udf_q;
        status_word[STS_LEVEL_LSB +: STS_LEVEL_W] = STS_LEVEL_W'(level);
    end

    always_comb begin
        state_d    = state_q;
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata     = '0;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        ovf_set    = 1'b0;
        ovf_clr    = 1'b0;
        udf_set    = 1'b0;
        udf_clr    = 1'b0;
`ifdef APB_FIFO_IRQ_EN
        thresh_d   = thresh_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    case (reg_off)
                        ADDR_DATA: begin
                            if (pwrite) begin
                                pready = 1'b1;
                                if (fifo_full) begin
                                    pslverr = 1'b1;
                                    ovf_set = 1'b1;
                                end else begin
                                    fifo_wr_en = 1'b1;
                                end
                            end else if (fifo_empty) begin
                                pready  = 1'b1;
                                pslverr = 1'b1;
                                udf_set = 1'b1;
                            end else begin
                                fifo_rd_en = 1'b1;
                                state_d    = RD_WAIT;
                            end
                        end
                        ADDR_STATUS: begin
                            pready = 1'b1;
                            if (pwrite) begin
                                ovf_clr = pwdata[STS_OVF];
                                udf_clr = pwdata[STS_UDF];
                            end else begin
                                prdata = status_word;
                            end
                        end
`ifdef APB_FIFO_IRQ_EN
                        ADDR_THRESH: begin
                            pready = 1'b1;
                            if (pwrite) begin
                                thresh_d = pwdata[7:0];
                            end else begin
                                prdata = PDATA_W'(thresh_q);
                            end
                        end
`endif
                        default: begin
                            pready  = 1'b1;
                            pslverr = 1'b1;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                // An aborted transfer still returns to IDLE; the popped word is dropped.
                state_d = IDLE;
                if (access) begin
                    pready = 1'b1;
                    prdata = PDATA_W'(fifo_dout);
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        udf_d = udf_set | (udf_q & ~udf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_level_cnt #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_level (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (fifo_wr_en),
        .dec_i   (fifo_rd_en),
        .level_o (level)
    );

`ifdef APB_FIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_q    <= (thresh_q != 8'd0) && (32'(level) >= 32'(thresh_q));
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/apb_fifo_bridge.md
Name: apb_fifo_bridge

Overview:
- APB3 slave that sits directly upstream of the fifo block and provides register-mapped push/pop access to it.
- APB writes to DATA push one word into the fifo; APB reads of DATA pop one word and return it.
- Also provides a shadow fill-level counter, sticky overflow/underflow flags, and an optional level-threshold interrupt.
- Integration drives the fifo rst_n from ~rst so the bridge and fifo always reset together.

Parameters:
- WIDTH, 8, fifo data width; must be <= PDATA_W.
- DEPTH, 16, fifo depth; sizes the level counter.
- ADDR_W, 4, APB address width; only paddr[3:2] are decoded.
- PDATA_W, 32, APB data bus width.

Ports:
- clk in 1 : single clock, shared with the fifo.
- rst in 1 : synchronous, active-high reset.
- psel in 1 : APB select.
- penable in 1 : APB enable.
- pwrite in 1 : 1 = write, 0 = read.
- paddr in ADDR_W : byte address.
- pwdata in PDATA_W : write data.
- prdata out PDATA_W : read data.
- pready out 1 : transfer complete.
- pslverr out 1 : error response, qualified by pready.
- fifo_wr_en out 1 : push strobe to the fifo.
- fifo_din out WIDTH : push data.
- fifo_rd_en out 1 : pop strobe to the fifo.
- fifo_dout in WIDTH : fifo read data, valid the cycle after fifo_rd_en is sampled.
- fifo_full in 1 : fifo full flag.
- fifo_empty in 1 : fifo empty flag.
- irq out 1 : threshold interrupt; exists only with APB_FIFO_IRQ_EN.

Behaviour:
- Register map:
  - 0x0 DATA: W = push, R = pop.
  - 0x4 STATUS (R):
    - [0] empty, [1] full.
    - [2] ovf_sticky, [3] udf_sticky.
    - [15:8] level, zero-extended.
    - All other bits 0.
  - 0x4 STATUS (W): W1C on bits [3:2]; all other bits ignored; pslverr = 0.
  - 0x8 unmapped.
  - 0xC unmapped, or THRESH when the optional feature is compiled in.
- Unmapped access: pready = 1, pslverr = 1, prdata = 0, no side effects.
- Transfers:
  - Setup phase: psel=1, penable=0.
  - Access phase: psel=1, penable=1.
  - Access completes in the cycle where pready=1.
  - pready and pslverr are 0 whenever psel & penable = 0.
- FSM states: IDLE, RD_WAIT.
  - IDLE, access to anything other than a non-empty DATA read: zero-wait completion (pready=1 in the first access cycle). Stay in IDLE.
  - IDLE, first access cycle of a DATA read with fifo_empty=0: fifo_rd_en = 1 for exactly one cycle, pready = 0, level decrements. Go to RD_WAIT.
  - RD_WAIT: pready = 1, prdata = {zeros, fifo_dout}, pslverr = 0. Return to IDLE.
  - RD_WAIT with psel=0 or penable=0 (protocol abort): return to IDLE; no additional pop. The popped word is lost.
- DATA write:
  - fifo_full=0: fifo_wr_en = 1 for one cycle, fifo_din = pwdata[WIDTH-1:0], level increments, pready=1.
  - fifo_full=1: no push, ovf_sticky set, pready=1, pslverr=1.
- DATA read with fifo_empty=1: no pop, udf_sticky set, prdata = 0, pready=1, pslverr=1.
- fifo_full and fifo_empty are sampled only in the first access cycle.
- Push and pop never occur in the same cycle, so level changes by at most ±1 per cycle and never wraps.
- Level range is 0..DEPTH; the counter is $clog2(DEPTH+1) bits wide.
- Sticky vs. W1C collision in the same cycle: the set takes priority over the clear.
- Reset (any cycle, including mid-transfer):
  - FSM goes to IDLE.
  - level = 0, ovf/udf stickies = 0, fifo_wr_en = fifo_rd_en = 0, prdata = 0, irq = 0.
  - Any in-flight transfer is dropped.

Optional Feature:
- Macro: APB_FIFO_IRQ_EN.
- Defined:
  - 0xC is THRESH, R/W, bits [7:0], reset 0.
  - irq is registered: irq = (THRESH != 0) && (level >= THRESH), updating one cycle after level or THRESH changes.
- Undefined: 0xC is unmapped (pslverr=1), the irq port is absent, and no THRESH flops exist.

Decomposition:
- Package apb_fifo_pkg:
  - Offset constants ADDR_DATA, ADDR_STATUS, ADDR_THRESH.
  - STATUS bit-position constants.
  - State enum typedef (IDLE, RD_WAIT).
- Sub-module fifo_level_cnt: inc/dec inputs, synchronous reset, level output; reusable by later fifo wrappers.

Test Plan:
- Reset, then write DATA 0xA5, then read DATA → fifo_wr_en pulses once with fifo_din=0xA5; read has 1 wait state, prdata=0x000000A5, pslverr=0; STATUS reads level 0, empty 1.
- 16 DATA writes 0x00..0x0F, then a 17th write 0xFF → 17th write gets pslverr=1 with no fifo_wr_en; STATUS = full 1, ovf_sticky 1, level 16; then write STATUS 0x4 → ovf_sticky clears, full stays 1.
- Read DATA while empty → pready=1 with zero wait, pslverr=1, prdata=0, udf_sticky=1, fifo_rd_en never asserted.
- Read 0x8 and write 0x8 → pslverr=1, prdata=0, level unchanged.
- Assert rst during RD_WAIT → next cycle FSM in IDLE, pready=0, level=0, stickies 0; a fresh read of a newly pushed 0x3C returns 0x3C.
- With APB_FIFO_IRQ_EN: write THRESH=4, push 4 words → irq rises one cycle after the 4th push; pop 1 → irq falls one cycle later; with THRESH=0, irq stays 0 at level 16.
